msft_dv_debug_apb_arb_stage: RTL

- Downstream stage of the 3-master debug APB mux.
- Sits between the mux output port and the single debug APB slave.
- Arbitrates the three master requests round-robin and drives the mux select.
- Regenerates a protocol-correct SETUP/ACCESS sequence on the slave side, so a master granted mid-wait never presents the slave with an access phase that had no setup.

---
 rtl/msft_dv_debug_apb_arb_stage_pkg.sv | 20 ++
 rtl/msft_dv_debug_apb_arb_stage_if.sv | 26 ++
 rtl/msft_dv_debug_apb_arb_stage_rr_arb3.sv | 29 ++
 rtl/msft_dv_debug_apb_arb_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/msft_dv_debug_apb_arb_stage_pkg.sv
// Shared types for the debug APB arbitration stage: master index,
// controller state encoding and the round-robin index helper.
package msft_dv_debug_apb_pkg;

    localparam int NUM_MASTERS = 3;

    typedef logic [1:0] mst_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Next master index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic mst_idx_t next_idx(input mst_idx_t idx);
        return (idx == mst_idx_t'(NUM_MASTERS - 1)) ? '0 : idx + mst_idx_t'(1);
    endfunction

endpackage

// File: rtl/msft_dv_debug_apb_arb_stage_if.sv
// APB bus bundle used on both sides of the arbitration stage.
// master modport: drives the request half (psel/penable/paddr/pwdata/pwrite).
// slave modport : drives the response half (prdata/pready/psuberr).
interface msft_dv_debug_apb_arb_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  psuberr;

    modport master (
        output psel, penable, paddr, pwdata, pwrite,
        input  prdata, pready, psuberr
    );

    modport slave (
        input  psel, penable, paddr, pwdata, pwrite,
        output prdata, pready, psuberr
    );
endinterface

// File: rtl/msft_dv_debug_apb_arb_stage_rr_arb3.sv
// Combinational 3-way rotate-priority picker. The search starts at the
// master after the last owner, so the last owner has lowest priority.
module msft_dv_debug_rr_arb3
    import msft_dv_debug_apb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  mst_idx_t               last,
    output mst_idx_t               winner,
    output logic                   valid
);

    mst_idx_t cand;

    // Walk last+1, last+2, last+3 (mod 3) and take the first requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        winner = last;
        valid  = 1'b0;
        cand   = last;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = next_idx(cand);
            if (!valid && req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msft_dv_debug_apb_arb_stage.sv
// Downstream stage of the 3-master debug APB mux. Arbitrates the master
// requests round-robin, drives the mux select, and regenerates a clean
// SETUP/ACCESS sequence toward the single debug slave.
// Optional feature macro: MSFT_DV_DEBUG_APB_ARB_TIMEOUT_EN (forced completion
// after TIMEOUT_CYCLES ACCESS cycles without slave ready).
module msft_dv_debug_apb_arb_stage
    import msft_dv_debug_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_MASTERS-1:0]         req_i,
    output mst_idx_t                       sel_o,
    msft_dv_debug_apb_arb_stage_if.slave   mux,
    msft_dv_debug_apb_arb_stage_if.master  slv,
    output logic                           abort_o,
    output logic                           timeout_o
);

    state_t   state_q, state_d;
    mst_idx_t sel_q,   sel_d;
    mst_idx_t last_q,  last_d;

    mst_idx_t arb_winner;
    logic     arb_valid;

    logic     psel_s;
    logic     penable_s;
    logic     pready_m;
    logic     psuberr_m;
    logic     abort_p;
    logic     timeout_p;

    msft_dv_debug_rr_arb3 u_arb (
        .req    (req_i),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

`ifdef MSFT_DV_DEBUG_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_hit;

    // cnt_q holds the number of ACCESS cycles already elapsed, so the
    // TIMEOUT_CYCLES-th ACCESS cycle sees TIMEOUT_CYCLES-1.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // ACCESS cycle counter, cleared while in SETUP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`endif

    // State, select and last-owner registers.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked branch and only acts on an edge.
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= mst_idx_t'(NUM_MASTERS - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state and slave/master handshake decode.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        pready_m  = 1'b0;
        psuberr_m = 1'b0;
        abort_p   = 1'b0;
        timeout_p = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    sel_d   = arb_winner;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                psel_s = 1'b1;
                if (!mux.psel) begin
                    abort_p = 1'b1;
                    state_d = IDLE;
                    last_d  = sel_q;
                end else begin
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                psel_s    = 1'b1;
                penable_s = 1'b1;
                // Slave ready wins over an owner drop or a timeout in the same cycle.
                if (slv.pready) begin
                    pready_m  = mux.penable;
                    psuberr_m = mux.penable & slv.psuberr;
                    state_d   = IDLE;
                    last_d    = sel_q;
                end else if (!mux.psel) begin
                    abort_p   = 1'b1;
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    state_d   = IDLE;
                    last_d    = sel_q;
                end
`ifdef MSFT_DV_DEBUG_APB_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    pready_m  = mux.penable;
                    psuberr_m = mux.penable;
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    timeout_p = 1'b1;
                    state_d   = IDLE;
                    last_d    = sel_q;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset mid-transfer drops the slave access immediately and never
        // hands a ready back to any master.
        if (rst_i) begin
            psel_s    = 1'b0;
            penable_s = 1'b0;
            pready_m  = 1'b0;
            psuberr_m = 1'b0;
            abort_p   = 1'b0;
            timeout_p = 1'b0;
        end
    end

    assign sel_o       = sel_q;
    assign abort_o     = abort_p;
    assign timeout_o   = timeout_p;

    assign slv.psel    = psel_s;
    assign slv.penable = penable_s;
    assign slv.paddr   = ADDR_WIDTH'(mux.paddr);
    assign slv.pwdata  = DATA_WIDTH'(mux.pwdata);
    assign slv.pwrite  = mux.pwrite;

    assign mux.prdata  = DATA_WIDTH'(slv.prdata);
    assign mux.pready  = pready_m;
    assign mux.psuberr = psuberr_m;

endmodule
